// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around mem_port_arbiter.
// slave = arbiter view; master = pipeline plus memory array view.
interface mem_port_arbiter_if #(
    parameter int AW = 10
);
    // Fetch port (read-only)
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;

    // Load/store port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;

    // Memory array side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Status
    logic          busy;
    logic          owner;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between the fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-priority with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    state_e        state_q;
    logic          owner_q;
    logic [2:0]    cnt_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic          if_ack_q;
    logic          d_ack_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;

`ifdef MEM_ARB_RR_EN
    logic          last_owner_q;
`else
    logic [2:0]    sc_q;
`endif

    logic          grant_d;
    logic          owner_d;

    // Arbitration decision, only consumed while the FSM is in S_IDLE.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_d = 1'b0;
        owner_d = OWNER_FETCH;
`ifdef MEM_ARB_RR_EN
        if (bus.if_req && bus.d_req) begin
            grant_d = 1'b1;
            owner_d = ~last_owner_q;
        end else if (bus.d_req) begin
            grant_d = 1'b1;
            owner_d = OWNER_DATA;
        end else if (bus.if_req) begin
            grant_d = 1'b1;
            owner_d = OWNER_FETCH;
        end
`else
        if (bus.d_req && !(bus.if_req && (sc_q == 3'(STARVE_MAX)))) begin
            grant_d = 1'b1;
            owner_d = OWNER_DATA;
        end else if (bus.if_req) begin
            grant_d = 1'b1;
            owner_d = OWNER_FETCH;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWNER_FETCH;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= 1'b0;
`else
            sc_q         <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_d) begin
                        owner_q  <= owner_d;
                        mem_en_q <= 1'b1;
                        state_q  <= S_ISSUE;
                        if (owner_d == OWNER_DATA) begin
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                            mem_we_q    <= bus.d_we;
                        end else begin
                            mem_addr_q  <= bus.if_addr;
                            mem_we_q    <= 1'b0;
                        end
                    end
`ifdef MEM_ARB_RR_EN
                    if (grant_d) begin
                        last_owner_q <= owner_d;
                    end
`else
                    // Starvation count only grows while fetch is actually waiting.
                    if (!bus.if_req) begin
                        sc_q <= '0;
                    end else if (grant_d && (owner_d == OWNER_DATA)) begin
                        sc_q <= sc_q + 3'd1;
                    end else if (grant_d) begin
                        sc_q <= '0;
                    end
`endif
                end

                S_ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        d_ack_q <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q   <= 3'(LAT);
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        if (owner_q == OWNER_DATA) begin
                            d_rdata_q <= bus.mem_rdata;
                            d_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ack_q   <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                S_RESP: begin
                    // Requests are deliberately not sampled here; a held request
                    // is re-arbitrated in the following S_IDLE cycle.
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    state_q  <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a LAT-stage memory model.
// Grant-order expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_port_arbiter;

    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int SM  = 3;

    logic clk1 = 1'b0;
    logic rst_n;

    always #5 clk1 = ~clk1;

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(
        .AW         (AW),
        .LAT        (LAT),
        .STARVE_MAX (SM)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: writes on mem_en&mem_we, read data appears LAT cycles after mem_en.
    logic [31:0] mem     [0:(1<<AW)-1];
    logic        written [0:(1<<AW)-1];
    logic [31:0] pipe    [0:LAT-1];

    function automatic logic [31:0] init_val(input logic [AW-1:0] a);
        case (a)
            10'd5:   return 32'h2801000a;
            10'd20:  return 32'h12345678;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk1) begin
        if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_en && !bus.mem_we)
            pipe[0] <= (written[bus.mem_addr] === 1'b1) ? mem[bus.mem_addr] : init_val(bus.mem_addr);
        else
            pipe[0] <= 32'h0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign bus.mem_rdata = pipe[LAT-1];

    int n_vec = 0;
    int n_bad = 0;

    // Monitor state, updated once per cycle from tick().
    logic grant_log[$];
    int   n_grants = 0;
    int   n_if_ack = 0;
    int   n_d_ack  = 0;
    int   orphans  = 0;
    logic pend_f   = 1'b0;
    logic pend_d   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (bus.mem_en === 1'b1) begin
            grant_log.push_back(bus.owner);
            n_grants++;
            if (bus.owner) pend_d = 1'b1;
            else           pend_f = 1'b1;
        end
        if (bus.if_ack === 1'b1) begin
            n_if_ack++;
            if (!pend_f) orphans++;
            pend_f = 1'b0;
        end
        if (bus.d_ack === 1'b1) begin
            n_d_ack++;
            if (!pend_d) orphans++;
            pend_d = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
        sample();
    endtask

    logic exp_order [8];
    int   guard;
    int   base;

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        rst_n       = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_owner",     bus.owner,     1'b0);
        check("rst_mem_en",    bus.mem_en,    1'b0);
        check("rst_mem_we",    bus.mem_we,    1'b0);
        check("rst_mem_addr",  bus.mem_addr,  '0);
        check("rst_mem_wdata", bus.mem_wdata, '0);
        check("rst_if_ack",    bus.if_ack,    1'b0);
        check("rst_d_ack",     bus.d_ack,     1'b0);
        check("rst_if_rdata",  bus.if_rdata,  '0);
        check("rst_d_rdata",   bus.d_rdata,   '0);
        rst_n = 1'b1;
        tick();

        // Single fetch of address 5: mem_en in cycle 1, if_ack in cycle 4
        bus.if_req  = 1'b1;
        bus.if_addr = 10'd5;
        check("f_no_comb_en", bus.mem_en, 1'b0);
        tick();
        check("f_c1_mem_en",   bus.mem_en,   1'b1);
        check("f_c1_mem_we",   bus.mem_we,   1'b0);
        check("f_c1_mem_addr", bus.mem_addr, 10'd5);
        check("f_c1_owner",    bus.owner,    1'b0);
        check("f_c1_busy",     bus.busy,     1'b1);
        tick();
        check("f_c2_mem_en", bus.mem_en, 1'b0);
        tick();
        check("f_c3_if_ack", bus.if_ack, 1'b0);
        tick();
        check("f_c4_if_ack",   bus.if_ack,   1'b1);
        check("f_c4_if_rdata", bus.if_rdata, 32'h2801000a);
        check("f_c4_d_ack",    bus.d_ack,    1'b0);
        bus.if_req = 1'b0;
        tick();
        check("f_c5_if_ack", bus.if_ack, 1'b0);
        check("f_c5_busy",   bus.busy,   1'b0);

        // Store deadbeef to 8, then load it back
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 10'd8;
        bus.d_wdata = 32'hdeadbeef;
        tick();
        check("st_mem_en",    bus.mem_en,    1'b1);
        check("st_mem_we",    bus.mem_we,    1'b1);
        check("st_mem_addr",  bus.mem_addr,  10'd8);
        check("st_mem_wdata", bus.mem_wdata, 32'hdeadbeef);
        check("st_owner",     bus.owner,     1'b1);
        tick();
        check("st_d_ack",   bus.d_ack,   1'b1);
        check("st_we_low",  bus.mem_we,  1'b0);
        check("st_d_rdata", bus.d_rdata, '0);
        bus.d_req = 1'b0;
        tick();
        check("st_ack_gone",  bus.d_ack,    1'b0);
        check("st_addr_hold", bus.mem_addr, 10'd8);
        check("st_memory",    mem[8],       32'hdeadbeef);
        bus.d_we    = 1'b0;
        bus.d_wdata = '0;
        bus.d_req   = 1'b1;
        tick();
        check("ld_mem_en", bus.mem_en, 1'b1);
        check("ld_mem_we", bus.mem_we, 1'b0);
        tick();
        tick();
        check("ld_no_early_ack", bus.d_ack, 1'b0);
        tick();
        check("ld_d_ack",     bus.d_ack,    1'b1);
        check("ld_d_rdata",   bus.d_rdata,  32'hdeadbeef);
        check("ld_if_rdata",  bus.if_rdata, 32'h2801000a);
        bus.d_req = 1'b0;
        tick();

        // Continuous contention from a fresh reset: grant order
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        grant_log.delete();
        bus.if_req  = 1'b1;
        bus.if_addr = 10'd20;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 10'd8;
        base  = n_if_ack + n_d_ack;
        guard = 0;
        while ((n_if_ack + n_d_ack - base) < 8 && guard < 200) begin
            tick();
            guard++;
        end
        check("arb_timeout", 32'(guard < 200), 32'd1);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        check("arb_grant_cnt", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("arb_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : 1'bx, exp_order[i]);
        check("arb_if_rdata", bus.if_rdata, 32'h12345678);
        check("arb_d_rdata",  bus.d_rdata,  32'hdeadbeef);
        check("arb_orphans",  orphans,      0);
        tick();

        // Reset during WAIT of a fetch: no ack, then clean re-issue
        base = n_if_ack;
        bus.if_req  = 1'b1;
        bus.if_addr = 10'd5;
        tick();
        tick();
        check("rw_in_wait", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rw_busy",     bus.busy,     1'b0);
        check("rw_mem_en",   bus.mem_en,   1'b0);
        check("rw_mem_addr", bus.mem_addr, '0);
        check("rw_if_rdata", bus.if_rdata, '0);
        check("rw_d_rdata",  bus.d_rdata,  '0);
        check("rw_owner",    bus.owner,    1'b0);
        check("rw_if_ack",   bus.if_ack,   1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (bus.if_ack !== 1'b1 && guard < 20);
        check("rw_ack_latency", guard,        4);
        check("rw_ack_count",   n_if_ack,     base + 1);
        check("rw_if_rdata2",   bus.if_rdata, 32'h2801000a);
        bus.if_req = 1'b0;
        tick();

        // Request held through ack: re-served only if still high in next IDLE
        base  = n_d_ack;
        guard = n_grants;
        bus.d_req  = 1'b1;
        bus.d_addr = 10'd8;
        repeat (4) tick();
        check("hold_a_ack", bus.d_ack, 1'b1);
        tick();
        check("hold_a_idle_en", bus.mem_en, 1'b0);
        bus.d_req = 1'b0;
        tick();
        check("hold_a_no_regrant", bus.mem_en, 1'b0);
        repeat (5) tick();
        check("hold_a_acks",   n_d_ack,  base + 1);
        check("hold_a_grants", n_grants, guard + 1);
        bus.d_req = 1'b1;
        repeat (4) tick();
        check("hold_b_ack", bus.d_ack, 1'b1);
        tick();
        check("hold_b_idle_en", bus.mem_en, 1'b0);
        tick();
        check("hold_b_regrant", bus.mem_en, 1'b1);
        bus.d_req = 1'b0;
        repeat (4) tick();
        check("hold_b_acks",  n_d_ack, base + 3);
        check("all_orphans",  orphans, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported synchronous instruction/data memory between the pipeline's fetch port (read-only) and its load/store port. Sits between the IF/MEM stages of the mips32 core and the memory array. Runs a per-transaction FSM with fixed-latency read return, request/acknowledge handshakes, and a starvation guard on the fetch side.

## Interface
- AW, 10: memory word-address width.
- LAT, 1: memory read latency in cycles, legal 1..4. Read data is valid LAT cycles after the cycle mem_en is high.
- STARVE_MAX, 3: maximum consecutive data grants while fetch is waiting; legal 1..7.

- clk1  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- if_req  in  1  fetch request, level; held until if_ack.
- if_addr  in  AW  fetch word address; stable while if_req high.
- if_ack  out  1  one-cycle pulse; fetch complete, if_rdata valid.
- if_rdata  out  32  fetched word; holds until the next fetch ack.
- d_req  in  1  data request, level; held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req high.
- d_addr  in  AW  data word address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle pulse; access complete.
- d_rdata  out  32  load data; updated on load acks only.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; high only together with mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- busy  out  1  state != IDLE.
- owner  out  1  0 = fetch, 1 = data; meaningful only while busy.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrates among asserted requests, latches the winner's address, write data and we, sets owner, and moves to ISSUE. With no requests, stays in IDLE.
- ISSUE: lasts 1 cycle. Drives mem_en=1 and mem_we=(owner & latched we), with mem_addr and mem_wdata taken from the latches.
  - Store goes next to RESP.
  - Read goes next to WAIT with cnt=LAT.
- WAIT: cnt decrements each cycle. In the cycle where cnt==1, mem_rdata is captured into if_rdata or d_rdata (chosen by owner), and the FSM goes to RESP.
- RESP: lasts 1 cycle. Asserts the owner's ack, then returns to IDLE. Requests are not sampled in RESP, so a requester that still holds req during its ack cycle is not re-served.
- Arbitration is fixed priority, with data above fetch.
  - The starve counter sc (3 bits) increments on each data grant made while if_req is high.
  - When sc==STARVE_MAX and if_req is high, fetch wins.
  - sc clears on any fetch grant, and on any arbitration where if_req is low.
- mem_en, mem_we, mem_addr and mem_wdata are decoded from registered state and latches only, with no combinational path from the request inputs. mem_addr and mem_wdata hold their last values outside ISSUE.
- Reset values: state=IDLE, sc=0, owner=0, if_ack=d_ack=mem_en=mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=d_rdata=0, busy=0.
- Reset asserted mid-transaction abandons the transaction with no ack. Requesters re-request after reset deasserts.

## Timing
- A request sampled high at the clock edge that ends IDLE cycle m produces:
  - mem_en high in cycle m+1.
  - Read: data captured at the end of cycle m+1+LAT, ack in cycle m+LAT+2.
  - Store: ack in cycle m+2.
- Back-to-back: the next arbitration happens in cycle m+LAT+3 for reads and m+3 for stores. Per-read occupancy is LAT+3 cycles.
- Simultaneous requests are resolved in the same IDLE cycle. The loser stays pending, and no ack is ever given without a grant.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A last_owner bit (reset 0) is set on every grant.
  - On contention, the port not equal to last_owner wins.
  - sc and STARVE_MAX are unused.
- MEM_ARB_RR_EN undefined: fixed priority with the starvation guard, as described under Operation.

## Test plan
- LAT=2, single fetch at if_addr=5 with mem[5]=32'h2801000a: req in cycle 0 -> mem_en in cycle 1, if_ack in cycle 4, if_rdata=32'h2801000a.
- Store d_addr=8, d_wdata=32'hdeadbeef: mem_we with mem_en in cycle 1, d_ack in cycle 2. A following load of address 8 returns 32'hdeadbeef.
- if_req and d_req held continuously, STARVE_MAX=3, macro off -> grant order D,D,D,F,D,D,D,F. No ack ever occurs without a preceding mem_en.
- Same stimulus with MEM_ARB_RR_EN defined -> grant order D,F,D,F (last_owner=0 after reset, so data wins first).
- rst_n pulsed low during WAIT of a fetch -> all outputs return to their reset values immediately, no if_ack occurs, and the re-issued request completes normally.
- Requester holds req high through its ack cycle -> exactly one ack, and the second grant occurs only if req is still high in the following IDLE cycle.
